// File: rtl/matmul_pkg.sv
// Shared definitions for the matrix-multiplier family: default element
// geometry, the inner-product sequencer state encoding and slice helpers.
package matmul_pkg;

    localparam int unsigned MATMUL_W = 32;
    localparam int unsigned MATMUL_N = 4;

    typedef enum logic [2:0] {
        SEQ_IDLE    = 3'd0,
        SEQ_ISSUE   = 3'd1,
        SEQ_WAIT    = 3'd2,
        SEQ_RELEASE = 3'd3,
        SEQ_FINISH  = 3'd4
    } seq_state_t;

    // Bit offset of element k inside a packed vector of w-bit elements.
    function automatic int unsigned elem_lsb(input int unsigned w, input int unsigned k);
        return w * k;
    endfunction

    // Bit offset of column j inside a packed set of n-element, w-bit columns.
    function automatic int unsigned col_lsb(input int unsigned w, input int unsigned n,
                                            input int unsigned j);
        return w * n * j;
    endfunction

endpackage

// File: rtl/inner_product_sequencer.sv
// Initiator-side controller for an external inner_product datapath: snapshots
// one A row and N B columns, issues N inner-product requests in turn and
// packs the N scalar results into one output row. Elements are copied as raw
// bits and never interpreted. A level-style ip_done is tolerated by waiting
// for it to drop before the next request.
module inner_product_sequencer
    import matmul_pkg::*;
#(
    parameter int unsigned N       = MATMUL_N,
    parameter int unsigned W       = MATMUL_W,
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [W*N-1:0]     row_in,
    input  logic [W*N*N-1:0]   cols_in,
    output logic [W*N-1:0]     ip_in1,
    output logic [W*N-1:0]     ip_in2,
    output logic               ip_start,
    input  logic [W-1:0]       ip_out,
    input  logic               ip_done,
    output logic [W*N-1:0]     result,
    output logic               done,
    output logic               busy,
    output logic               timeout_err
);

    localparam int unsigned J_W = $clog2(N);
    localparam int unsigned C_W = $clog2(TIMEOUT + 1);
    localparam logic [J_W-1:0] J_LAST  = J_W'(N - 1);
    localparam logic [C_W-1:0] CNT_MAX = C_W'(TIMEOUT);

    seq_state_t           state_q, state_d;
    logic [J_W-1:0]       j_q, j_d;
    logic [C_W-1:0]       cnt_q, cnt_d;
    logic [W*N-1:0]       row_q, row_d;
    logic [W*N*N-1:0]     cols_q, cols_d;
    logic [W*N-1:0]       result_q, result_d;
    logic                 terr_q, terr_d;
    logic                 ip_start_q;
    logic                 done_q;
    logic                 busy_q;

    logic [W*N-1:0]       col_sel_s [N];
    logic [W*N-1:0]       result_wr_s;

    // Per-column views of the snapshot and the row with slice j replaced by ip_out.
    for (genvar k = 0; k < N; k++) begin : g_slice
        assign col_sel_s[k] = cols_q[col_lsb(W, N, k) +: W*N];
        assign result_wr_s[elem_lsb(W, k) +: W] =
            (j_q == J_W'(k)) ? ip_out : result_q[elem_lsb(W, k) +: W];
    end

    // Next-state logic for the request/collect sequence.
    always_comb begin
        state_d  = state_q;
        j_d      = j_q;
        cnt_d    = cnt_q;
        row_d    = row_q;
        cols_d   = cols_q;
        result_d = result_q;
        terr_d   = terr_q;
        case (state_q)
            SEQ_IDLE: begin
                if (start) begin
                    row_d    = row_in;
                    cols_d   = cols_in;
                    result_d = '0;
                    terr_d   = 1'b0;
                    j_d      = '0;
                    cnt_d    = '0;
                    state_d  = SEQ_ISSUE;
                end else begin
                    state_d  = SEQ_IDLE;
                end
            end
            SEQ_ISSUE: begin
                // ip_done seen here belongs to no request of ours, so it is ignored.
                cnt_d   = '0;
                state_d = SEQ_WAIT;
            end
            SEQ_WAIT: begin
                if (ip_done) begin
                    result_d = result_wr_s;
                    state_d  = SEQ_RELEASE;
                end else if (cnt_q == CNT_MAX) begin
                    terr_d   = 1'b1;
                    state_d  = SEQ_FINISH;
                end else begin
                    cnt_d    = cnt_q + C_W'(1);
                end
            end
            SEQ_RELEASE: begin
                if (!ip_done) begin
                    if (j_q == J_LAST) begin
                        state_d = SEQ_FINISH;
                    end else begin
                        j_d     = j_q + J_W'(1);
                        state_d = SEQ_ISSUE;
                    end
                end else begin
                    state_d = SEQ_RELEASE;
                end
            end
            SEQ_FINISH: begin
                state_d = SEQ_IDLE;
            end
            default: begin
                state_d = SEQ_IDLE;
            end
        endcase
    end

    // State, snapshot and registered status outputs, decoded from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= SEQ_IDLE;
            j_q        <= '0;
            cnt_q      <= '0;
            row_q      <= '0;
            cols_q     <= '0;
            result_q   <= '0;
            terr_q     <= 1'b0;
            ip_start_q <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            j_q        <= j_d;
            cnt_q      <= cnt_d;
            row_q      <= row_d;
            cols_q     <= cols_d;
            result_q   <= result_d;
            terr_q     <= terr_d;
            ip_start_q <= (state_d == SEQ_ISSUE);
            done_q     <= (state_d == SEQ_FINISH);
            busy_q     <= (state_d != SEQ_IDLE);
        end
    end

    assign ip_in1      = row_q;
    assign ip_in2      = col_sel_s[j_q];
    assign ip_start    = ip_start_q;
    assign result      = result_q;
    assign done        = done_q;
    assign busy        = busy_q;
    assign timeout_err = terr_q;

endmodule

// File: doc/inner_product_sequencer.md
# inner_product_sequencer

Initiator-side controller for the `inner_product` datapath. It accepts one packed row of matrix A and N packed columns of matrix B. It then issues N back-to-back inner-product requests over the `In1/In2/start/out/done` interface and assembles the N scalar results into one packed output row. It sits between the matrix-multiplier top level and an external `inner_product` instance, and instantiates no arithmetic itself.

## Interface
- `N`, 4: elements per vector; columns per row. Must be ≥2.
- `W`, 32: element width in bits, IEEE-754 single. Bits are only copied, never interpreted.
- `TIMEOUT`, 1023: maximum cycles spent in WAIT before the current row is aborted.

Ports:
- `clk`  in  1  sole clock; rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request; sampled only in IDLE.
- `row_in`  in  W*N  A row; element k at `[W*k +: W]`.
- `cols_in`  in  W*N*N  B columns; column j at `[W*N*j +: W*N]`.
- `ip_in1`  out  W*N  operand 1 to `inner_product` (latched row).
- `ip_in2`  out  W*N  operand 2 to `inner_product` (latched column j).
- `ip_start`  out  1  one-cycle request pulse.
- `ip_out`  in  W  scalar result from `inner_product`.
- `ip_done`  in  1  result valid; may be a pulse or a level.
- `result`  out  W*N  output row; element j at `[W*j +: W]`.
- `done`  out  1  one-cycle pulse when the row is complete or aborted.
- `busy`  out  1  high in every state except IDLE.
- `timeout_err`  out  1  sticky abort flag; cleared on the next accepted start.

## Operation
- States: IDLE, ISSUE, WAIT, RELEASE, FINISH. Column counter `j` is clog2(N) bits. Timeout counter is clog2(TIMEOUT+1) bits.
- **IDLE.** On `start=1`:
  - snapshot `row_in` and `cols_in` into internal registers;
  - clear `result` and `timeout_err`;
  - set `j=0`;
  - go to ISSUE.
- **ISSUE.**
  - `ip_start=1` for exactly this cycle.
  - `ip_in1` = snapshot row; `ip_in2` = snapshot column j.
  - Next state: WAIT, with the timeout counter cleared.
- **WAIT.**
  - Operands held stable; `ip_start=0`.
  - If `ip_done=1`: write `ip_out` into `result[W*j +: W]`, go to RELEASE.
  - Else, if the counter equals TIMEOUT: set `timeout_err`, go to FINISH. Slices not yet written stay 0.
  - Else: increment the counter.
- **RELEASE.** Wait for `ip_done=0`, so a level-style done cannot be captured twice. Then:
  - if `j==N-1`, go to FINISH;
  - else `j=j+1` and go to ISSUE.
- **FINISH.** `done=1` for one cycle, then return to IDLE.
- `start` in any non-IDLE state is ignored; no queueing.
- Input changes after acceptance have no effect on the row in flight, because operands come from the snapshot.
- `result` holds its value from FINISH until the next accepted start.
- Reset, including mid-operation:
  - state ← IDLE, `j` ← 0, counters ← 0;
  - `ip_start`, `done`, `busy`, `timeout_err` ← 0;
  - `result`, `ip_in1`, `ip_in2` ← 0.
- Result capture and `done` are registered outputs.

## Timing
- `start` sampled high in cycle s puts ISSUE in cycle s+1.
- Let `ip_start` be high in cycle c and the responder raise a one-cycle `ip_done` in cycle c+L, with L≥1:
  - capture happens at the end of c+L;
  - RELEASE runs in c+L+1;
  - the next ISSUE is in c+L+2.
  - Per-column cost is therefore L+2 cycles.
- `done` is high in cycle s+1+N·(L+2).
  - Example: N=4, L=3 gives done at s+21.
- A level-style `ip_done` held for H cycles adds H−1 RELEASE cycles per column.
- `ip_done=1` in the same cycle as `ip_start` (the ISSUE cycle) is ignored.
- `busy` rises in cycle s+1 and falls in the cycle after FINISH.

## Structure
- Shared package `matmul_pkg` holds:
  - default `W` and `N` constants;
  - the state enum `seq_state_t`;
  - slice-index helper functions, reused by the future top-level matrix multiplier.
- No sub-module. This block is pure control plus registers; the `inner_product` instance lives in the parent.

## Test plan
Benches use a behavioural `inner_product` responder model: latency L, `ip_out = 0x40000000 + j`.
- **Basic row.** N=4, L=3, one-cycle done, `row_in` = {10.75, 5.89, 6.48, 4.98}, arbitrary columns.
  - `done` at s+21.
  - `result` = {0x40000003, 0x40000002, 0x40000001, 0x40000000}, MSB slice first.
  - Exactly 4 `ip_start` pulses, each with correct column operands.
- **Level done.** Responder holds `ip_done` high 3 cycles.
  - Each slice written once; no double increment of `j`.
  - `done` at s+1+4·(3+2)+4·2 = s+29.
- **Snapshot integrity.** Change `row_in`/`cols_in` and pulse `start` again while busy.
  - `ip_in1`/`ip_in2` remain the original values.
  - Second start ignored; only one `done`.
- **Timeout.** TIMEOUT=15; responder never answers column 2.
  - `timeout_err=1`; `done` pulses once.
  - Slices 0–1 written; slices 2–3 = 0.
  - Next start clears `timeout_err`.
- **Reset mid-operation.** Assert `rst` during the WAIT of column 1.
  - Next cycle: all outputs 0, `busy=0`.
  - A subsequent start completes normally.
- **Back-to-back rows.** `start` held high continuously.
  - New row accepted in the IDLE cycle after FINISH.
  - `result` updates only during the second row.
